// File: rtl/char_pkg.sv
// Character codes and word defaults shared by the rotator and the 2-bit 7-segment decoders.
package char_pkg;

  localparam int unsigned CW       = 2;
  localparam int unsigned N_DIGITS = 4;

  typedef enum logic [CW-1:0] {
    CH_D     = 2'b00,
    CH_E     = 2'b01,
    CH_1     = 2'b10,
    CH_BLANK = 2'b11
  } char_t;

  // digit3..digit0 reads "d E 1 blank"; digit0 sits in the LSBs
  localparam logic [N_DIGITS*CW-1:0] DEFAULT_WORD = {CH_D, CH_E, CH_1, CH_BLANK};

  // Rotation offset after one step, modulo n (dir=0 counts up, dir=1 counts down)
  function automatic int unsigned pos_step(input int unsigned p, input int unsigned n,
                                           input logic dir);
    if (dir) return (p == 0) ? n - 1 : p - 1;
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/char_rotator_if.sv
// Control/data bundle between the character rotator and its driver (switches, keys, HEX decoders).
interface char_rotator_if #(
  parameter int unsigned N_DIGITS = char_pkg::N_DIGITS,
  parameter int unsigned CW       = char_pkg::CW
);

  localparam int unsigned WW = N_DIGITS * CW;
  localparam int unsigned PW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic          load;
  logic [WW-1:0] word_in;
  logic          run;
  logic          dir;
  logic          step;
  logic [WW-1:0] chars;
  logic [PW-1:0] pos;
  logic          tick;

  modport master (
    output load, word_in, run, dir, step,
    input  chars, pos, tick
  );

  modport slave (
    input  load, word_in, run, dir, step,
    output chars, pos, tick
  );

endinterface

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 counter that holds while disabled; tick marks the wrap cycle.
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & (cnt == LAST);

  // clr restarts the period; wrap and increment only advance while enabled
  always_ff @(posedge CLOCK_50) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/char_rotator.sv
// Holds an N-digit word of character codes and rotates it one digit per auto or manual step,
// feeding one code per HEX digit so the word scrolls across the display.
module char_rotator #(
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned STEP_HZ  = 1,
  parameter int unsigned N_DIGITS = char_pkg::N_DIGITS,
  parameter int unsigned CW       = char_pkg::CW,
  parameter logic [N_DIGITS*CW-1:0] RESET_WORD = char_pkg::DEFAULT_WORD
) (
  input  logic           CLOCK_50,
  input  logic           RESET,
  char_rotator_if.slave  bus
);

  import char_pkg::*;

  localparam int unsigned DIV = CLK_HZ / STEP_HZ;
  localparam int unsigned WW  = N_DIGITS * CW;
  localparam int unsigned PW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic          auto_tick;
  logic          step_meta;
  logic          step_sync;
  logic          step_prev;
  logic          man_tick;
  logic          step_c;
  logic [WW-1:0] rot_c;
  logic [PW-1:0] pos_nxt_c;
  logic [WW-1:0] chars_q;
  logic [PW-1:0] pos_q;
  logic          tick_q;

  tick_divider #(
    .DIV (DIV)
  ) u_div (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .en       (bus.run),
    .clr      (bus.load),
    .tick     (auto_tick)
  );

  // Two-flop synchronizer for the pushbutton plus one flop of history for edge detect
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      step_meta <= 1'b0;
      step_sync <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_meta <= bus.step;
      step_sync <= step_meta;
      step_prev <= step_sync;
    end
  end

  assign man_tick = step_sync & ~step_prev;
  // Coincident auto and manual events merge into a single rotation
  assign step_c   = auto_tick | man_tick;

  always_comb begin
    rot_c     = chars_q;
    pos_nxt_c = PW'(pos_step(32'(pos_q), N_DIGITS, bus.dir));
    if (bus.dir) begin
      rot_c = {chars_q[CW-1:0], chars_q[WW-1:CW]};
    end else begin
      rot_c = {chars_q[WW-CW-1:0], chars_q[WW-1 -: CW]};
    end
  end

  // Load wins over a coincident step, which is dropped
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      chars_q <= RESET_WORD;
      pos_q   <= '0;
      tick_q  <= 1'b0;
    end else if (bus.load) begin
      chars_q <= bus.word_in;
      pos_q   <= '0;
      tick_q  <= 1'b0;
    end else if (step_c) begin
      chars_q <= rot_c;
      pos_q   <= pos_nxt_c;
      tick_q  <= 1'b1;
    end else begin
      tick_q  <= 1'b0;
    end
  end

  assign bus.chars = chars_q;
  assign bus.pos   = pos_q;
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_char_rotator.sv
// Randomised and scripted bench for char_rotator with a digit/offset reference model and scoreboard.
module tb_char_rotator;

  localparam int N   = 4;
  localparam int W   = 2;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst;

  char_rotator_if #(.N_DIGITS(N), .CW(W)) bus ();

  char_rotator #(
    .CLK_HZ     (8),
    .STEP_HZ    (1),
    .N_DIGITS   (N),
    .CW         (W),
    .RESET_WORD (8'b00_01_10_11)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] chars;
    logic [1:0] pos;
    logic       tick;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: loaded digits, signed rotation offset, run-cycle count, sampled STEP history
  int base[N];
  int mpos;
  bit mtick;
  int run_count;
  bit hist[3];

  function automatic void load_base(input logic [7:0] w);
    for (int i = 0; i < N; i++) base[i] = int'((w >> (i * W)) & 8'h3);
  endfunction

  // After p left rotations, displayed digit i came from loaded digit (i - p) mod N
  function automatic logic [7:0] model_chars();
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = r | (8'(base[(i - mpos + N) % N]) << (i * W));
    return r;
  endfunction

  function automatic void model_edge(input bit r, input bit ld, input logic [7:0] w,
                                     input bit rn, input bit d, input bit st);
    bit man, auto_t;
    if (r) begin
      load_base(8'h1B);
      mpos = 0; mtick = 0; run_count = 0;
      hist[0] = 0; hist[1] = 0; hist[2] = 0;
      return;
    end
    man    = hist[1] && !hist[2];
    auto_t = rn && ((run_count % DIV) == DIV - 1);
    if (ld) begin
      load_base(w);
      mpos = 0; mtick = 0; run_count = 0;
    end else begin
      if (rn) run_count++;
      if (man || auto_t) begin
        mpos  = d ? (mpos + N - 1) % N : (mpos + 1) % N;
        mtick = 1;
      end else begin
        mtick = 0;
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = st;
  endfunction

  task automatic cyc(input bit r, input bit ld, input logic [7:0] w,
                     input bit rn, input bit d, input bit st);
    exp_t e;
    rst         = r;
    bus.load    = ld;
    bus.word_in = w;
    bus.run     = rn;
    bus.dir     = d;
    bus.step    = st;
    model_edge(r, ld, w, rn, d, st);
    e.chars = model_chars();
    e.pos   = 2'(mpos);
    e.tick  = mtick;
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Scoreboard monitor: one expectation per clock edge, sampled just after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        mon_e = expq.pop_front();
        n_checks++;
        if ({bus.chars, bus.pos, bus.tick} !== mon_e) begin
          n_fail++;
          $display("FAIL scoreboard: got chars=%h pos=%0d tick=%b expected chars=%h pos=%0d tick=%b at %0t",
                   bus.chars, bus.pos, bus.tick, mon_e.chars, mon_e.pos, mon_e.tick, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bit rn, d, st, r, ld;
    rst = 1'b1; bus.load = 0; bus.word_in = '0; bus.run = 0; bus.dir = 0; bus.step = 0;
    @(negedge clk);

    // Reset then idle
    cyc(1, 0, 8'h00, 0, 0, 0);
    repeat (20) cyc(0, 0, 8'h00, 0, 0, 0);
    check("idle_chars", bus.chars, 8'h1B);
    check("idle_pos", 8'(bus.pos), 8'd0);

    // Auto rotate left through a full wrap
    repeat (8) cyc(0, 0, 8'h00, 1, 0, 0);
    check("left1_chars", bus.chars, 8'h6C);
    check("left1_pos", 8'(bus.pos), 8'd1);
    check("left1_tick", 8'(bus.tick), 8'd1);
    repeat (24) cyc(0, 0, 8'h00, 1, 0, 0);
    check("wrap_chars", bus.chars, 8'h1B);
    check("wrap_pos", 8'(bus.pos), 8'd0);

    // Rotate right, then freeze the divider at cnt=5
    repeat (8) cyc(0, 0, 8'h00, 1, 1, 0);
    check("right1_chars", bus.chars, 8'hC6);
    check("right1_pos", 8'(bus.pos), 8'd3);
    repeat (5) cyc(0, 0, 8'h00, 1, 1, 0);
    repeat (10) cyc(0, 0, 8'h00, 0, 1, 0);
    repeat (2) cyc(0, 0, 8'h00, 1, 1, 0);
    check("resume_early_tick", 8'(bus.tick), 8'd0);
    cyc(0, 0, 8'h00, 1, 1, 0);
    check("resume_tick", 8'(bus.tick), 8'd1);
    check("resume_chars", bus.chars, 8'hB1);

    // Load on the auto_tick edge: step dropped, period restarts
    repeat (7) cyc(0, 0, 8'h00, 1, 0, 0);
    cyc(0, 1, 8'hE4, 1, 0, 0);
    check("load_chars", bus.chars, 8'hE4);
    check("load_pos", 8'(bus.pos), 8'd0);
    check("load_tick", 8'(bus.tick), 8'd0);
    repeat (7) cyc(0, 0, 8'h00, 1, 0, 0);
    check("load_early_tick", 8'(bus.tick), 8'd0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check("load_next_chars", bus.chars, 8'h93);

    // Held STEP with RUN=0 gives exactly one rotation on the 3rd edge
    repeat (2) cyc(0, 0, 8'h00, 0, 0, 1);
    check("step_wait_chars", bus.chars, 8'h93);
    cyc(0, 0, 8'h00, 0, 0, 1);
    check("step_chars", bus.chars, 8'h4E);
    check("step_pos", 8'(bus.pos), 8'd2);
    repeat (37) cyc(0, 0, 8'h00, 0, 0, 1);
    check("step_held_chars", bus.chars, 8'h4E);
    repeat (5) cyc(0, 0, 8'h00, 0, 0, 0);

    // Manual step coinciding with auto_tick: one rotation only
    cyc(0, 1, 8'h1B, 1, 0, 0);
    repeat (5) cyc(0, 0, 8'h00, 1, 0, 0);
    repeat (3) cyc(0, 0, 8'h00, 1, 0, 1);
    check("coincide_pos", 8'(bus.pos), 8'd1);
    check("coincide_chars", bus.chars, 8'h6C);
    cyc(0, 0, 8'h00, 1, 0, 1);
    check("coincide_after_pos", 8'(bus.pos), 8'd1);
    repeat (3) cyc(0, 0, 8'h00, 0, 0, 0);

    // Reset mid-sequence at POS=2, cnt=4
    cyc(1, 0, 8'h00, 0, 0, 0);
    repeat (20) cyc(0, 0, 8'h00, 1, 0, 0);
    check("pre_reset_pos", 8'(bus.pos), 8'd2);
    cyc(1, 0, 8'h00, 1, 0, 0);
    check("mid_reset_chars", bus.chars, 8'h1B);
    check("mid_reset_pos", 8'(bus.pos), 8'd0);
    repeat (7) cyc(0, 0, 8'h00, 1, 0, 0);
    check("post_reset_early_tick", 8'(bus.tick), 8'd0);
    cyc(0, 0, 8'h00, 1, 0, 0);
    check("post_reset_tick", 8'(bus.tick), 8'd1);

    // Randomised traffic
    rn = 1; d = 0; st = 0;
    repeat (800) begin
      r  = ($urandom_range(149) == 0);
      ld = ($urandom_range(39) == 0);
      if ($urandom_range(29) == 0) rn = ~rn;
      if ($urandom_range(19) == 0) d = ~d;
      if ($urandom_range(9) == 0) st = ~st;
      cyc(r, ld, 8'($urandom), rn, d, st);
    end

    @(posedge clk);
    #2;
    check("queue_drained", 8'(expq.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
